// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the multicycle data-memory controller, the
// behavioural SRAM and the CPU top / bench memory model.
//   state_t            controller FSM encoding (IDLE, ACCESS, DONE)
//   DEFAULT_BASE_ADDR  CPU byte address that maps to SRAM word 0
//   calc_beats()       number of SRAM beats per CPU word
//   addr_shift()       byte-address to word-index shift amount
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEFAULT_BASE_ADDR = 1024;

  function automatic int calc_beats(input int data_w, input int sram_data_w);
    return data_w / sram_data_w;
  endfunction

  function automatic int addr_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sram_model.sv
// sram_model: behavioural asynchronous-read SRAM used in front of the
// controller in simulation. Writes happen on every rising edge with we_n low.
// It also watches the write bus: every write bundle (addr, wdata, we_n=0)
// must stay unchanged for at least WAIT_CYCLES sampled cycles, otherwise the
// sticky err flag is raised.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (checker state only)
//   addr, wdata    SRAM word address and write data
//   we_n           active-low write strobe
//   rdata          read data, combinational from addr
//   err            sticky: a write bundle was held for too few cycles
module sram_model #(
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic                   we_n,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   err
);

  logic [SRAM_DATA_W-1:0] mem [0:(1 << SRAM_ADDR_W) - 1];
  logic [SRAM_ADDR_W-1:0] prev_addr;
  logic [SRAM_DATA_W-1:0] prev_wdata;
  logic                   prev_we_n;
  logic [15:0]            hold;
  logic                   same;

  assign rdata = mem[addr];
  assign same  = (addr == prev_addr) && (wdata == prev_wdata) && (we_n == prev_we_n);

  // Storage is deliberately not reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (!we_n) mem[addr] <= wdata;
  end

  // hold counts how many sampled cycles the current bundle has lasted; when
  // the bundle changes, the length of the finished segment is judged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_addr  <= '0;
      prev_wdata <= '0;
      prev_we_n  <= 1'b1;
      hold       <= '0;
      err        <= 1'b0;
    end else begin
      prev_addr  <= addr;
      prev_wdata <= wdata;
      prev_we_n  <= we_n;
      if (same) begin
        if (hold != 16'hFFFF) hold <= hold + 16'd1;
      end else begin
        if (!prev_we_n && (int'(hold) < WAIT_CYCLES)) err <= 1'b1;
        hold <= 16'd1;
      end
    end
  end

endmodule

// File: rtl/mem_wait_controller.sv
// mem_wait_controller: multicycle data-memory controller for the MEM stage.
// Each DATA_W-bit load/store becomes BEATS = DATA_W/SRAM_DATA_W narrow SRAM
// accesses, each held on the bus for WAIT_CYCLES cycles, least-significant
// slice first.
//
// Handshake: ready is the pipeline advance signal. In IDLE it is the inverse
// of the request, so the cycle that raises rd_en/wr_en already freezes the
// pipeline. It stays low through ACCESS and is high for exactly one cycle in
// DONE, the edge on which the pipeline advances past the request. The request
// must be held until that cycle; its contents are latched at the IDLE edge
// and later changes are ignored.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   rd_en, wr_en           load / store request (store wins if both)
//   address, write_data    CPU byte address and store data
//   read_data              registered load result
//   ready                  1 = pipeline may advance, 0 = freeze
//   sram_addr/wdata/rdata  SRAM word address, write data, read data
//   sram_we_n              SRAM active-low write strobe
//   state_dbg              current FSM state
module mem_wait_controller
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_wdata,
  input  logic [SRAM_DATA_W-1:0] sram_rdata,
  output logic                   sram_we_n,
  output state_t                 state_dbg
);

  localparam int BEATS  = calc_beats(DATA_W, SRAM_DATA_W);
  localparam int SHIFT  = addr_shift(DATA_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t              state, state_next;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   beat_inc;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                op_wr;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   word_q;
  logic [ADDR_W-1:0]   word_in;
  logic                req;
  logic                wait_last;
  logic                beat_last;

  assign req       = rd_en | wr_en;
  // Subtraction wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land at
  // the top of the SRAM rather than faulting.
  assign word_in   = (address - ADDR_W'(BASE_ADDR)) >> SHIFT;
  assign wait_last = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
  assign beat_last = (beat == BEAT_W'(BEATS - 1));
  assign beat_inc  = beat + 1'b1;
  assign state_dbg = state;

  function automatic logic [SRAM_ADDR_W-1:0] sram_index(
    input logic [ADDR_W-1:0] word,
    input logic [BEAT_W-1:0] b
  );
    logic [ADDR_W-1:0] lin;
    lin = word * ADDR_W'(BEATS) + ADDR_W'(b);
    return lin[SRAM_ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    case (state)
      ST_IDLE: begin
        ready = ~req;
        if (req) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        ready = 1'b0;
        if (wait_last && beat_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The SRAM bus is loaded one edge ahead of each beat, so sram_addr,
  // sram_wdata and sram_we_n are stable for the whole beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat       <= '0;
      wait_cnt   <= '0;
      op_wr      <= 1'b0;
      wdata_q    <= '0;
      word_q     <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          sram_we_n <= 1'b1;
          if (req) begin
            op_wr      <= wr_en;
            wdata_q    <= write_data;
            word_q     <= word_in;
            beat       <= '0;
            wait_cnt   <= '0;
            sram_addr  <= sram_index(word_in, '0);
            sram_wdata <= write_data[SRAM_DATA_W-1:0];
            sram_we_n  <= ~wr_en;
          end
        end
        ST_ACCESS: begin
          if (!wait_last) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
            if (!op_wr) read_data[int'(beat)*SRAM_DATA_W +: SRAM_DATA_W] <= sram_rdata;
            if (beat_last) begin
              sram_we_n <= 1'b1;
            end else begin
              beat       <= beat_inc;
              sram_addr  <= sram_index(word_q, beat_inc);
              sram_wdata <= wdata_q[int'(beat_inc)*SRAM_DATA_W +: SRAM_DATA_W];
            end
          end
        end
        ST_DONE: begin
          sram_we_n <= 1'b1;
        end
        default: begin
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_controller.sv
// Bench for mem_wait_controller. Three controller/SRAM pairs share one clock
// and reset: inst0 defaults (16-bit SRAM, 3 waits), inst1 8-bit SRAM with
// 1 wait, inst2 32-bit SRAM (single beat). The driver pushes the expected
// access into exp_q; the monitor follows each access cycle by cycle and pops
// it when ready returns high.
module tb_mem_wait_controller;
  import mem_pkg::*;

  typedef struct {
    int          inst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } exp_t;

  logic clk;
  logic rst;
  logic        rd_en_a   [3];
  logic        wr_en_a   [3];
  logic [31:0] addr_a    [3];
  logic [31:0] wdata_a   [3];
  logic [31:0] read_data_a [3];
  logic        ready_a   [3];
  logic [17:0] sram_addr_a [3];
  logic [31:0] sram_wdata_a [3];
  logic        we_n_a    [3];
  state_t      state_a   [3];
  logic        err_a     [3];

  logic [31:0] rd0, rd1, rd2;
  logic        rdy0, rdy1, rdy2;
  logic [17:0] sa0, sa1, sa2;
  logic [15:0] sw0, sr0;
  logic [7:0]  sw1, sr1;
  logic [31:0] sw2, sr2;
  logic        we0, we1, we2;
  state_t      st0, st1, st2;
  logic        err0, err1, err2;

  exp_t        exp_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] last_rd [3];
  int          lowcnt [3];
  logic        post_done [3];
  int          done_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  mem_wait_controller #(.SRAM_DATA_W(16), .WAIT_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en_a[0]), .wr_en(wr_en_a[0]),
    .address(addr_a[0]), .write_data(wdata_a[0]), .read_data(rd0), .ready(rdy0),
    .sram_addr(sa0), .sram_wdata(sw0), .sram_rdata(sr0), .sram_we_n(we0), .state_dbg(st0));
  sram_model #(.SRAM_DATA_W(16), .SRAM_ADDR_W(18), .WAIT_CYCLES(3)) sram0 (
    .clk(clk), .rst_n(rst), .addr(sa0), .wdata(sw0), .we_n(we0), .rdata(sr0), .err(err0));

  mem_wait_controller #(.SRAM_DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en_a[1]), .wr_en(wr_en_a[1]),
    .address(addr_a[1]), .write_data(wdata_a[1]), .read_data(rd1), .ready(rdy1),
    .sram_addr(sa1), .sram_wdata(sw1), .sram_rdata(sr1), .sram_we_n(we1), .state_dbg(st1));
  sram_model #(.SRAM_DATA_W(8), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)) sram1 (
    .clk(clk), .rst_n(rst), .addr(sa1), .wdata(sw1), .we_n(we1), .rdata(sr1), .err(err1));

  mem_wait_controller #(.SRAM_DATA_W(32), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd_en_a[2]), .wr_en(wr_en_a[2]),
    .address(addr_a[2]), .write_data(wdata_a[2]), .read_data(rd2), .ready(rdy2),
    .sram_addr(sa2), .sram_wdata(sw2), .sram_rdata(sr2), .sram_we_n(we2), .state_dbg(st2));
  sram_model #(.SRAM_DATA_W(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(3)) sram2 (
    .clk(clk), .rst_n(rst), .addr(sa2), .wdata(sw2), .we_n(we2), .rdata(sr2), .err(err2));

  always_comb begin
    read_data_a[0] = rd0;  read_data_a[1] = rd1;  read_data_a[2] = rd2;
    ready_a[0] = rdy0;     ready_a[1] = rdy1;     ready_a[2] = rdy2;
    sram_addr_a[0] = sa0;  sram_addr_a[1] = sa1;  sram_addr_a[2] = sa2;
    sram_wdata_a[0] = 32'(sw0); sram_wdata_a[1] = 32'(sw1); sram_wdata_a[2] = sw2;
    we_n_a[0] = we0;       we_n_a[1] = we1;       we_n_a[2] = we2;
    state_a[0] = st0;      state_a[1] = st1;      state_a[2] = st2;
    err_a[0] = err0;       err_a[1] = err1;       err_a[2] = err2;
  end

  // ---------------- per-instance configuration ----------------
  function automatic int sw_of(input int i);
    case (i)
      0: return 16;
      1: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int wait_of(input int i);
    return (i == 1) ? 1 : 3;
  endfunction

  function automatic int beats_of(input int i);
    return 32 / sw_of(i);
  endfunction

  function automatic logic [31:0] key_of(input int i, input logic [31:0] addr);
    logic [31:0] w;
    w = ((addr - 32'd1024) >> 2) & 32'h000F_FFFF;
    return (32'(i) << 20) | w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        lowcnt[i]    = 0;
        post_done[i] = 1'b0;
      end else begin
        if (post_done[i]) begin
          chk($sformatf("i%0d_done_one_cycle", i), 32'(state_a[i] == ST_DONE), 32'd0);
          post_done[i] = 1'b0;
        end
        if (!ready_a[i]) begin
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            if (lowcnt[i] == 0) chk($sformatf("i%0d_unexpected_access", i), 32'd1, 32'd0);
          end else if (lowcnt[i] == 0) begin
            chk($sformatf("i%0d_req_cycle_we_n", i), 32'(we_n_a[i]), 32'd1);
          end else begin
            int          beat;
            logic [31:0] lin;
            logic [63:0] slice;
            beat = (lowcnt[i] - 1) / wait_of(i);
            if (beat < beats_of(i)) begin
              lin = ((exp_q[0].addr - 32'd1024) >> 2) * 32'(beats_of(i)) + 32'(beat);
              chk($sformatf("i%0d_bus_addr_b%0d", i, beat), 32'(sram_addr_a[i]), 32'(lin[17:0]));
              chk($sformatf("i%0d_bus_we_n_b%0d", i, beat), 32'(we_n_a[i]), 32'(!exp_q[0].wr));
              if (exp_q[0].wr) begin
                slice = (64'(exp_q[0].wdata) >> (beat * sw_of(i))) & ((64'd1 << sw_of(i)) - 64'd1);
                chk($sformatf("i%0d_bus_wdata_b%0d", i, beat), sram_wdata_a[i], slice[31:0]);
              end
            end
          end
          lowcnt[i]++;
        end else if (lowcnt[i] > 0) begin
          if (exp_q.size() != 0 && exp_q[0].inst == i) begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("i%0d_ready_low_cycles", i), 32'(lowcnt[i]),
                32'(1 + beats_of(i) * wait_of(i)));
            chk($sformatf("i%0d_read_data", i), read_data_a[i], e.exp_rd);
            chk($sformatf("i%0d_done_state", i), 32'(state_a[i]), 32'(ST_DONE));
            chk($sformatf("i%0d_done_we_n", i), 32'(we_n_a[i]), 32'd1);
          end
          lowcnt[i]    = 0;
          post_done[i] = 1'b1;
          done_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drop_req(input int i);
    rd_en_a[i] = 1'b0;
    wr_en_a[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // edge that ends the DONE cycle.
  task automatic access(input int i, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic keep);
    exp_t e;
    int   target;
    int   cyc;
    e.inst  = i;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    if (wr) begin
      model_mem[key_of(i, addr)] = wdata;
      e.exp_rd = last_rd[i];
    end else begin
      e.exp_rd = model_mem.exists(key_of(i, addr)) ? model_mem[key_of(i, addr)] : 32'd0;
      last_rd[i] = e.exp_rd;
    end
    exp_q.push_back(e);
    rd_en_a[i] = rd;
    wr_en_a[i] = wr;
    addr_a[i]  = addr;
    wdata_a[i] = wdata;
    target = done_cnt + 1;
    cyc = 0;
    while (done_cnt < target && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (done_cnt < target) begin
      chk($sformatf("i%0d_timeout", i), 32'd1, 32'd0);
      exp_q.delete();
      drop_req(i);
    end else if (!keep) begin
      drop_req(i);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_i%0d_ready", tag, i), 32'(ready_a[i]), 32'd1);
      chk($sformatf("%s_i%0d_we_n", tag, i), 32'(we_n_a[i]), 32'd1);
      chk($sformatf("%s_i%0d_read_data", tag, i), read_data_a[i], 32'd0);
      chk($sformatf("%s_i%0d_state", tag, i), 32'(state_a[i]), 32'(ST_IDLE));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drop_req(i);
      addr_a[i]  = 32'd0;
      wdata_a[i] = 32'd0;
      last_rd[i] = 32'd0;
      lowcnt[i]  = 0;
      post_done[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_reset_state("por");
    for (int i = 0; i < 3; i++)
      chk($sformatf("por_i%0d_sram_addr", i), 32'(sram_addr_a[i]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Defaults: store, load, back-to-back, low-bit alias, conflict, wrap.
    access(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
    idle(1);
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    idle(1);
    access(0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b1);
    access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
    access(0, 1'b1, 1'b0, 32'd1034, 32'h0, 1'b0);
    idle(2);
    access(0, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0);
    access(0, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
    idle(1);
    access(0, 1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1'b0);
    access(0, 1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
    idle(1);

    // 8-bit SRAM, one wait state: four beats, little-endian.
    access(1, 1'b0, 1'b1, 32'd1032, 32'h11223344, 1'b0);
    access(1, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h55667788, 1'b1);
    access(1, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1020, 32'h0F1E2D3C, 1'b0);
    access(1, 1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
    idle(1);

    // 32-bit SRAM: single beat.
    access(2, 1'b0, 1'b1, 32'd1036, 32'h89ABCDEF, 1'b0);
    access(2, 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
    access(2, 1'b0, 1'b1, 32'd1020, 32'h13579BDF, 1'b1);
    access(2, 1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
    idle(2);

    // Reset in the middle of a store.
    begin
      exp_t e;
      e.inst = 0; e.wr = 1'b1; e.addr = 32'd1100; e.wdata = 32'h0BADF00D; e.exp_rd = last_rd[0];
      exp_q.push_back(e);
      wr_en_a[0] = 1'b1;
      addr_a[0]  = 32'd1100;
      wdata_a[0] = 32'h0BADF00D;
      idle(3);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        drop_req(i);
        last_rd[i] = 32'd0;
      end
      exp_q.delete();
      #1;
      check_reset_state("mid_rst");
      idle(3);
      rst = 1'b1;
      idle(1);
      check_reset_state("post_rst");
    end

    // Recovery after reset: SRAM contents are untouched.
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    access(0, 1'b0, 1'b1, 32'd1048, 32'h76543210, 1'b0);
    idle(2);

    for (int i = 0; i < 3; i++)
      chk($sformatf("i%0d_sram_hold_err", i), 32'(err_a[i]), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wait_controller.md
Name: mem_wait_controller

Overview:
- Parametrised multicycle data-memory controller that replaces the single-cycle data memory in the MEM stage.
- Splits each DATA_W-bit load/store into BEATS narrow accesses to an external SRAM, with a programmable wait-state count per beat.
- Drops `ready` while busy. The CPU top uses `~ready` as a global freeze for the IF/ID/EX/MEM stage registers, alongside the hazard freeze.

Parameters:
- DATA_W, 32: CPU data word width.
- ADDR_W, 32: CPU byte-address width.
- SRAM_DATA_W, 16: SRAM data bus width. DATA_W must be a multiple of it. BEATS = DATA_W/SRAM_DATA_W.
- SRAM_ADDR_W, 18: SRAM word-address width.
- WAIT_CYCLES, 3: cycles each beat is held on the SRAM bus. Must be ≥1.
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- rd_en  in  1  load request, held by the frozen pipeline until the access completes.
- wr_en  in  1  store request, held likewise.
- address  in  ADDR_W  CPU byte address (ALU result).
- write_data  in  DATA_W  store data (Val_Rm).
- read_data  out  DATA_W  load result, registered.
- ready  out  1  1 = pipeline may advance; 0 = freeze.
- sram_addr  out  SRAM_ADDR_W  SRAM word address.
- sram_wdata  out  SRAM_DATA_W  SRAM write data.
- sram_rdata  in  SRAM_DATA_W  SRAM read data.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat and wait counters cleared.
  - read_data=0, sram_addr=0, sram_wdata=0, sram_we_n=1.
  - ready=1 (no request pending).
  - Reset mid-access abandons the access immediately; no partial-write recovery.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - ready = ~(rd_en|wr_en), combinational, so the request cycle itself freezes.
  - On a request, latch op (wr_en wins if both are asserted), address, write_data and the computed word index; go to ACCESS with beat=0, wait=0.
  - The SRAM bus is idle (sram_we_n=1).
- Address mapping:
  - word = (address − BASE_ADDR) >> log2(DATA_W/8), modulo 2^ADDR_W.
  - sram_addr = word*BEATS + beat, truncated to SRAM_ADDR_W (silent wrap; no range check).
  - Low two byte-address bits are ignored.
- ACCESS:
  - ready=0. sram_addr is registered and driven for the current beat for WAIT_CYCLES cycles.
  - Store: sram_wdata = write_data slice [beat], with beat 0 = least-significant slice. sram_we_n=0 for all WAIT_CYCLES cycles of every beat.
  - Load: sram_we_n=1. On the last wait cycle of the beat, sram_rdata is captured into read_data slice [beat].
  - After the last wait cycle of beat BEATS−1, go to DONE.
- DONE:
  - ready=1 for exactly one cycle; read_data holds the full word; sram_we_n=1.
  - Next state is always IDLE. The still-asserted request is ignored this cycle because the pipeline advances on this edge.
- Timing:
  - ready is low for 1 + BEATS*WAIT_CYCLES consecutive cycles per access; total occupancy is 2 + BEATS*WAIT_CYCLES cycles.
  - Back-to-back requests: the new request is seen in the IDLE cycle following DONE.
- read_data retains its value until the next load overwrites it. Stores do not modify it.
- Request inputs that change during ACCESS are ignored (latched copy used).

Decomposition:
- Shared package (mem_pkg):
  - state encoding localparams (IDLE, ACCESS, DONE)
  - the BEATS and address-shift helper function
  - default BASE_ADDR constant, shared with the CPU top and the testbench memory model
- One natural sub-module: sram_model, a behavioural SRAM with SRAM_DATA_W/SRAM_ADDR_W parameters, bench-only, that checks data is stable for WAIT_CYCLES cycles.
- The controller itself stays a single module.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-store → sram_we_n=1, ready=1, read_data=0 immediately; FSM in IDLE after release.
- Store, defaults: wr_en=1, address=1032, write_data=0xDEADBEEF → ready low 7 cycles. sram_addr=4 with wdata=0xBEEF and we_n=0 for 3 cycles, then sram_addr=5 with wdata=0xDEAD for 3 cycles; ready=1 on cycle 8.
- Load: rd_en=1, address=1032 after the above → read_data=0xDEADBEEF in the DONE cycle; ready low exactly 7 cycles; we_n stays 1.
- Back-to-back: store followed immediately by a load to address 1024 → second access starts the cycle after DONE; no lost or merged beats.
- Parameter sweep: DATA_W=32, SRAM_DATA_W=8, WAIT_CYCLES=1 → 4 beats, ready low 5 cycles, byte order little-endian. Also check SRAM_DATA_W=32 (BEATS=1).
- Conflict and wrap: rd_en=wr_en=1 → treated as store. address=BASE_ADDR−4 → sram_addr wraps to all-ones−(BEATS−1) truncated, with no error.
